// File: rtl/dmem_line_responder.sv
// ============================================================================
// Module   : dmem_line_responder
// Brief    : Line-granular data memory behind the data cache; each line is moved
//            one word per cycle, followed by a configurable wait and a 1-cycle ack.
// Options  : `define DMEM_PRELOAD_EN preloads the array (word 0 = `DMEM_PRELOAD_WORD0).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_line_responder_pkg;
  localparam int DMEM_LINE_W = 128;
  localparam int DMEM_ADDR_W = 32;

  typedef struct packed {
    logic                   req;
    logic                   w_en;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_LINE_W-1:0] w_data;
  } type_dcache2dmem_s;

  typedef struct packed {
    logic                   ack;
    logic [DMEM_LINE_W-1:0] r_data;
  } type_dmem2dcache_s;
endpackage

module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int LINE_W      = DMEM_LINE_W,
  parameter int WORD_W      = 32,
  parameter int DEPTH_LINES = 1024,
  parameter int LAT_CYC     = 2,
  parameter int ADDR_W      = DMEM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmem_sel_i,
  input  type_dcache2dmem_s dcache2dmem_i,
  output type_dmem2dcache_s dmem2dcache_o
);

  localparam int BEATS     = LINE_W / WORD_W;
  localparam int OFF       = $clog2(LINE_W / 8);
  localparam int IDX_W     = $clog2(DEPTH_LINES);
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W     = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;
  localparam int MEM_WORDS = DEPTH_LINES * BEATS;
  localparam int MEM_AW    = $clog2(MEM_WORDS);
  localparam int LSB_W     = $clog2(LINE_W);

  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  c_LAST_WAIT = LAT_W'((LAT_CYC > 0) ? LAT_CYC - 1 : 0);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_XFER  = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_ACK   = 3'd3;
  localparam logic [2:0] c_ST_DRAIN = 3'd4;

  logic [2:0]        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [LAT_W-1:0]  r_wait;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rbuf;
  logic [LINE_W-1:0] r_rdata;
  logic              r_ack;

  logic [WORD_W-1:0] r_mem [MEM_WORDS];

  logic [MEM_AW-1:0] w_mem_addr;
  logic [LSB_W-1:0]  w_lsb;
  logic [WORD_W-1:0] w_rword;
  logic [WORD_W-1:0] w_wword;
  logic              w_mem_we;
  logic              w_unused_addr;

  // Word address of the current beat: lines are stored as BEATS consecutive words.
  assign w_mem_addr = MEM_AW'(int'(r_idx) * BEATS + int'(r_beat));
  assign w_lsb      = LSB_W'(int'(r_beat) * WORD_W);
  assign w_rword    = r_mem[w_mem_addr];
  assign w_wword    = r_wdata[w_lsb +: WORD_W];
  assign w_mem_we   = (r_state == c_ST_XFER) && r_we;

  assign w_unused_addr = ^{dcache2dmem_i.addr[ADDR_W-1:OFF+IDX_W], dcache2dmem_i.addr[OFF-1:0]};

`ifdef DMEM_PRELOAD_EN
`ifndef DMEM_PRELOAD_WORD0
`define DMEM_PRELOAD_WORD0 32'hDEADBEEF
`endif
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) r_mem[i] = '0;
    r_mem[0] = WORD_W'(`DMEM_PRELOAD_WORD0);
  end
`else
  // Contents stay undefined until written.
`endif

  // No reset here: an aborted transfer leaves its completed beats in place.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_wword;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_ST_IDLE;
      r_beat  <= '0;
      r_wait  <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (dcache2dmem_i.req && dmem_sel_i) begin
            r_idx   <= dcache2dmem_i.addr[OFF+IDX_W-1:OFF];
            r_we    <= dcache2dmem_i.w_en;
            r_wdata <= dcache2dmem_i.w_data;
            r_beat  <= '0;
            r_state <= c_ST_XFER;
          end
        end
        c_ST_XFER: begin
          if (!r_we) r_rbuf[w_lsb +: WORD_W] <= w_rword;
          if (r_beat == c_LAST_BEAT) begin
            r_wait  <= '0;
            r_state <= (LAT_CYC > 0) ? c_ST_WAIT : c_ST_ACK;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        c_ST_WAIT: begin
          if (r_wait == c_LAST_WAIT) r_state <= c_ST_ACK;
          else                       r_wait  <= r_wait + 1'b1;
        end
        c_ST_ACK: begin
          r_ack <= 1'b1;
          if (!r_we) r_rdata <= r_rbuf;
          r_state <= c_ST_DRAIN;
        end
        c_ST_DRAIN: begin
          // The cache may still hold req in the ack cycle; wait for it to drop.
          if (!dcache2dmem_i.req) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign dmem2dcache_o.ack    = r_ack;
  assign dmem2dcache_o.r_data = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
// ============================================================================
// Module   : tb_dmem_line_responder
// Brief    : Scoreboard bench for dmem_line_responder (default build).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_line_responder;
  import dmem_line_responder_pkg::*;

  localparam int BEATS   = 4;
  localparam int LAT     = 2;
  localparam int LAT_TOT = BEATS + LAT + 1;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004;
  localparam logic [127:0] D3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DMIX = 128'hA5A5_0001_5A5A_0002_5555_6666_7777_8888;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              dmem_sel_i;
  type_dcache2dmem_s d2m;
  type_dmem2dcache_s m2d;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           cyc;
    bit           rd;
    logic [127:0] data;
  } exp_t;
  exp_t sb[$];

  logic [127:0] held = '0;
  bit           prev_ack = 1'b0;

  dmem_line_responder #(
    .LINE_W(128), .WORD_W(32), .DEPTH_LINES(1024), .LAT_CYC(LAT), .ADDR_W(32)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dmem_sel_i   (dmem_sel_i),
    .dcache2dmem_i(d2m),
    .dmem2dcache_o(m2d)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ack, otherwise checks r_data is held.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      chk("rst_ack", {127'd0, m2d.ack}, 128'd0);
      chk("rst_rdata", m2d.r_data, 128'd0);
      held     = '0;
      prev_ack = 1'b0;
    end else begin
      if (m2d.ack) begin
        chk("ack_not_consecutive", {127'd0, prev_ack}, 128'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=1, expected ack=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", 128'(cyc), 128'(e.cyc));
          if (e.rd) held = e.data;
          chk("ack_rdata", m2d.r_data, held);
        end
      end else begin
        chk("rdata_held", m2d.r_data, held);
      end
      prev_ack = m2d.ack;
    end
  end

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk_i); #1;
      if (m2d.ack) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack, expected one within 40 cycles");
    end
  endtask

  // Request held until ack; inputs are scrambled after acceptance to show they are not resampled.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [127:0] wd,
                     input logic [127:0] exp);
    bit got;
    got = 1'b0;
    @(negedge clk_i); #1;
    dmem_sel_i = 1'b1;
    d2m.req    = 1'b1;
    d2m.w_en   = we;
    d2m.addr   = addr;
    d2m.w_data = wd;
    sb.push_back('{cyc + 1 + LAT_TOT, !we, exp});
    @(negedge clk_i); #1;
    d2m.addr   = ~addr;
    d2m.w_data = ~wd;
    d2m.w_en   = ~we;
    if (m2d.ack) got = 1'b1;
    if (!got) wait_ack(got);
    d2m.req = 1'b0;
  endtask

  initial begin
    bit got;
    rst_ni     = 1'b0;
    dmem_sel_i = 1'b1;
    d2m        = '0;
    d2m.req    = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    d2m.req = 1'b0;
    rst_ni  = 1'b1;
    repeat (3) @(negedge clk_i);

    // Write/read pairs, including an address whose upper bits wrap onto line 0x40.
    txn(1'b1, 32'h0000_0040, D1, '0);
    txn(1'b0, 32'h0000_0040, '0, D1);
    txn(1'b1, 32'h0000_0080, D3, '0);
    txn(1'b0, 32'h0000_0080, '0, D3);
    txn(1'b1, 32'h0000_4040, D2, '0);
    txn(1'b0, 32'h0000_0040, '0, D2);

    // Select gating, then req held past ack.
    @(negedge clk_i); #1;
    dmem_sel_i = 1'b0;
    d2m.req    = 1'b1;
    d2m.w_en   = 1'b0;
    d2m.addr   = 32'h0000_0040;
    d2m.w_data = '0;
    repeat (5) @(negedge clk_i);
    #1;
    dmem_sel_i = 1'b1;
    sb.push_back('{cyc + 1 + LAT_TOT, 1'b1, D2});
    wait_ack(got);
    repeat (3) @(negedge clk_i);
    #1;
    d2m.req = 1'b0;
    txn(1'b0, 32'h0000_4040, '0, D2);

    // Reset during a write, after two beats have landed.
    @(negedge clk_i); #1;
    d2m.req    = 1'b1;
    d2m.w_en   = 1'b1;
    d2m.addr   = 32'h0000_0040;
    d2m.w_data = D3;
    repeat (3) @(negedge clk_i);
    #1;
    rst_ni  = 1'b0;
    d2m.req = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    txn(1'b0, 32'h0000_0040, '0, DMIX);
    txn(1'b0, 32'h0000_0080, '0, D3);

    repeat (10) @(negedge clk_i);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
